tmr_err_monitor: RTL and testbench

Error-monitoring stage that sits directly downstream of the configurable TMR voter. It consumes the voter's per-signal error vectors and reduces them to per-replica fault event counts and to sticky permanent-fault flags for replicas that fail on consecutive cycles. A health state machine (OK / DEGRADED / ISOLATED / FAILED) drives a one-cycle interrupt pulse on every state change, for use by the core's fault-management logic.

---
 rtl/tmr_err_monitor.sv | 150 +++++++++++++++
 tb/tb_tmr_err_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tmr_err_monitor.sv
// rtl/tmr_err_monitor.sv - reduces TMR voter error vectors to per-replica fault counts, sticky flags and a health FSM
module tmr_err_monitor #(
    parameter int TNBEO     = 5,
    parameter int CNT_W     = 16,
    parameter int PERM_N    = 4,
    parameter int QUIET_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TNBEO-1:0] err_detected_1_i,
    input  logic [TNBEO-1:0] err_detected_2_i,
    input  logic [TNBEO-1:0] err_detected_3_i,
    input  logic [TNBEO-1:0] err_corrected_i,
    input  logic [TNBEO-1:0] err_detected_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] fault_cnt_1_o,
    output logic [CNT_W-1:0] fault_cnt_2_o,
    output logic [CNT_W-1:0] fault_cnt_3_o,
    output logic [2:0]       perm_fault_o,
    output logic             uncorrectable_o,
    output logic [1:0]       state_o,
    output logic             irq_o
);

    localparam int RUN_W = $clog2(PERM_N + 1);
    localparam int QW    = $clog2(QUIET_CYC + 1);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_ISOLATED = 2'b10,
        ST_FAILED   = 2'b11
    } state_t;

    logic [2:0]       w_ed;
    logic             w_corr;
    logic             w_unc;
    logic             w_any;
    logic [2:0]       w_perm_hit;
    logic [2:0]       w_perm_new;
    logic             w_quiet_done;
    logic [QW-1:0]    w_quiet_next;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_fault_cnt [3];
    logic [RUN_W-1:0] r_run [3];
    logic [2:0]       r_perm_fault;
    logic             r_unc;
    logic [QW-1:0]    r_quiet;
    state_t           r_state;
    logic             r_irq;

    assign w_ed[0] = |err_detected_1_i;
    assign w_ed[1] = |err_detected_2_i;
    assign w_ed[2] = |err_detected_3_i;
    assign w_corr  = |err_corrected_i;
    assign w_unc   = |(err_detected_i & ~err_corrected_i);
    assign w_any   = (|w_ed) | w_corr | w_unc;

    // A hit fires only on the cycle the run reaches PERM_N; the run then parks there.
    always_comb begin
        w_perm_hit = 3'b000;
        for (int k = 0; k < 3; k++) begin
            w_perm_hit[k] = w_ed[k] && (r_run[k] == RUN_W'(PERM_N - 1));
        end
        w_perm_new = w_perm_hit & ~r_perm_fault;
    end

    assign w_quiet_done = (r_state == ST_DEGRADED) && !w_any &&
                          (r_quiet == QW'(QUIET_CYC - 1));

    always_comb begin
        w_quiet_next = '0;
        if (!clear_i && (r_state == ST_DEGRADED) && !w_any && !w_quiet_done) begin
            w_quiet_next = r_quiet + QW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = ST_OK;
        end else if (w_unc) begin
            w_state_next = ST_FAILED;
        end else if (r_state == ST_FAILED) begin
            w_state_next = ST_FAILED;
        end else if ((|w_perm_new) || (r_state == ST_ISOLATED)) begin
            w_state_next = ST_ISOLATED;
        end else if ((r_state == ST_OK) && w_any) begin
            w_state_next = ST_DEGRADED;
        end else if (w_quiet_done) begin
            w_state_next = ST_OK;
        end
    end

    // irq is registered alongside the state so the pulse lines up with the new state_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OK;
            r_irq   <= 1'b0;
            r_quiet <= '0;
        end else begin
            r_state <= w_state_next;
            r_irq   <= (w_state_next != r_state);
            r_quiet <= w_quiet_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_fault_cnt[k] <= '0;
                r_run[k]       <= '0;
            end
            r_perm_fault <= 3'b000;
            r_unc        <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < 3; k++) begin
                r_fault_cnt[k] <= '0;
                r_run[k]       <= '0;
            end
            r_perm_fault <= 3'b000;
            r_unc        <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_ed[k]) begin
                    if (r_fault_cnt[k] != {CNT_W{1'b1}}) begin
                        r_fault_cnt[k] <= r_fault_cnt[k] + CNT_W'(1);
                    end
                    if (r_run[k] != RUN_W'(PERM_N)) begin
                        r_run[k] <= r_run[k] + RUN_W'(1);
                    end
                end else begin
                    r_run[k] <= '0;
                end
            end
            r_perm_fault <= r_perm_fault | w_perm_hit;
            r_unc        <= r_unc | w_unc;
        end
    end

    assign fault_cnt_1_o   = r_fault_cnt[0];
    assign fault_cnt_2_o   = r_fault_cnt[1];
    assign fault_cnt_3_o   = r_fault_cnt[2];
    assign perm_fault_o    = r_perm_fault;
    assign uncorrectable_o = r_unc;
    assign state_o         = r_state;
    assign irq_o           = r_irq;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// tb/tb_tmr_err_monitor.sv - self-checking bench for tmr_err_monitor
module tb_tmr_err_monitor;

    logic        clk;
    logic        rst;
    logic [4:0]  ed1, ed2, ed3, corr, det;
    logic        clr;

    logic [15:0] c1, c2, c3;
    logic [2:0]  perm;
    logic        unc;
    logic [1:0]  st;
    logic        irq;

    logic [3:0]  d2_c1, d2_c2, d2_c3;
    logic [2:0]  d2_perm;
    logic        d2_unc;
    logic [1:0]  d2_st;
    logic        d2_irq;

    tmr_err_monitor #(.TNBEO(5), .CNT_W(16), .PERM_N(4), .QUIET_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .err_detected_1_i(ed1), .err_detected_2_i(ed2), .err_detected_3_i(ed3),
        .err_corrected_i(corr), .err_detected_i(det), .clear_i(clr),
        .fault_cnt_1_o(c1), .fault_cnt_2_o(c2), .fault_cnt_3_o(c3),
        .perm_fault_o(perm), .uncorrectable_o(unc), .state_o(st), .irq_o(irq)
    );

    tmr_err_monitor #(.TNBEO(5), .CNT_W(4), .PERM_N(1), .QUIET_CYC(3)) dut2 (
        .clk(clk), .rst(rst),
        .err_detected_1_i(ed1), .err_detected_2_i(ed2), .err_detected_3_i(ed3),
        .err_corrected_i(corr), .err_detected_i(det), .clear_i(clr),
        .fault_cnt_1_o(d2_c1), .fault_cnt_2_o(d2_c2), .fault_cnt_3_o(d2_c3),
        .perm_fault_o(d2_perm), .uncorrectable_o(d2_unc), .state_o(d2_st), .irq_o(d2_irq)
    );

    typedef struct {
        logic [4:0]  e1, e2, e3, co, de;
        logic        cl;
        logic [1:0]  st;
        logic        irq;
        logic [2:0]  perm;
        logic        unc;
        logic [15:0] c1, c2, c3;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                       input logic [4:0] co, input logic [4:0] de, input logic cl,
                       input logic [1:0] s, input logic q, input logic [2:0] p, input logic u,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        vec_t v;
        v.e1 = e1; v.e2 = e2; v.e3 = e3; v.co = co; v.de = de; v.cl = cl;
        v.st = s; v.irq = q; v.perm = p; v.unc = u; v.c1 = a; v.c2 = b; v.c3 = c;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic drive(input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                         input logic [4:0] co, input logic [4:0] de, input logic cl);
        ed1 = e1; ed2 = e2; ed3 = e3; corr = co; det = de; clr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t e;
        drive(tbl[idx].e1, tbl[idx].e2, tbl[idx].e3, tbl[idx].co, tbl[idx].de, tbl[idx].cl);
        exp_q.push_back(tbl[idx]);
        tick();
        e = exp_q.pop_front();
        chk($sformatf("v%0d.state", idx), 32'(st),   32'(e.st));
        chk($sformatf("v%0d.irq", idx),   32'(irq),  32'(e.irq));
        chk($sformatf("v%0d.perm", idx),  32'(perm), 32'(e.perm));
        chk($sformatf("v%0d.unc", idx),   32'(unc),  32'(e.unc));
        chk($sformatf("v%0d.cnt1", idx),  32'(c1),   32'(e.c1));
        chk($sformatf("v%0d.cnt2", idx),  32'(c2),   32'(e.c2));
        chk($sformatf("v%0d.cnt3", idx),  32'(c3),   32'(e.c3));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, 32'(st), 0);
        chk({tag, ".irq"},   32'(irq), 0);
        chk({tag, ".perm"},  32'(perm), 0);
        chk({tag, ".unc"},   32'(unc), 0);
        chk({tag, ".cnt1"},  32'(c1), 0);
        chk({tag, ".cnt2"},  32'(c2), 0);
        chk({tag, ".cnt3"},  32'(c3), 0);
        chk({tag, ".d2_state"}, 32'(d2_st), 0);
        chk({tag, ".d2_irq"},   32'(d2_irq), 0);
        chk({tag, ".d2_cnt1"},  32'(d2_c1), 0);
    endtask

    initial begin
        //   n    ed1    ed2    ed3    corr   det   clr  st    irq perm    unc cnt1 cnt2 cnt3
        add(10,  5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd0, 0, 3'b000, 0, 0, 0, 0);
        add(1,   5'h00, 5'h04, 5'h00, 5'h04, 5'h00, 0, 2'd1, 1, 3'b000, 0, 0, 1, 0);
        add(63,  5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd1, 0, 3'b000, 0, 0, 1, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd0, 1, 3'b000, 0, 0, 1, 0);
        // event in the last quiet cycle restarts the 64-cycle count
        add(1,   5'h01, 5'h00, 5'h00, 5'h01, 5'h00, 0, 2'd1, 1, 3'b000, 0, 1, 1, 0);
        add(63,  5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd1, 0, 3'b000, 0, 1, 1, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h08, 5'h00, 0, 2'd1, 0, 3'b000, 0, 1, 1, 0);
        add(63,  5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd1, 0, 3'b000, 0, 1, 1, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd0, 1, 3'b000, 0, 1, 1, 0);
        add(1,   5'h00, 5'h00, 5'h10, 5'h10, 5'h00, 0, 2'd1, 1, 3'b000, 0, 1, 1, 1);
        add(1,   5'h00, 5'h00, 5'h10, 5'h10, 5'h00, 0, 2'd1, 0, 3'b000, 0, 1, 1, 2);
        add(1,   5'h00, 5'h00, 5'h10, 5'h10, 5'h00, 0, 2'd1, 0, 3'b000, 0, 1, 1, 3);
        add(1,   5'h00, 5'h00, 5'h10, 5'h10, 5'h00, 0, 2'd2, 1, 3'b100, 0, 1, 1, 4);
        add(1,   5'h00, 5'h00, 5'h10, 5'h00, 5'h00, 1, 2'd0, 1, 3'b000, 0, 0, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd0, 0, 3'b000, 0, 0, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 0, 2'd3, 1, 3'b000, 1, 0, 0, 0);
        add(200, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 2'd3, 0, 3'b000, 1, 0, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 1, 2'd0, 1, 3'b000, 0, 0, 0, 0);
        // perm detection and unc together: FAILED wins, perm bit still latches
        add(1,   5'h01, 5'h00, 5'h00, 5'h01, 5'h00, 0, 2'd1, 1, 3'b000, 0, 1, 0, 0);
        add(1,   5'h01, 5'h00, 5'h00, 5'h01, 5'h00, 0, 2'd1, 0, 3'b000, 0, 2, 0, 0);
        add(1,   5'h01, 5'h00, 5'h00, 5'h01, 5'h00, 0, 2'd1, 0, 3'b000, 0, 3, 0, 0);
        add(1,   5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 0, 2'd3, 1, 3'b001, 1, 4, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1, 2'd0, 1, 3'b000, 0, 0, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h01, 5'h02, 0, 2'd3, 1, 3'b000, 1, 0, 0, 0);
        add(1,   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1, 2'd0, 1, 3'b000, 0, 0, 0, 0);
        add(1,   5'h00, 5'h04, 5'h00, 5'h04, 5'h00, 0, 2'd1, 1, 3'b000, 0, 0, 1, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_reset_vals("in_reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(i);
        chk("sb_empty", 32'(exp_q.size()), 0);

        // small instance: QUIET_CYC=3, PERM_N=1, CNT_W=4
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("d2_clear.state", 32'(d2_st), 0);
        drive(0, 0, 0, 5'h01, 0, 0); tick();
        chk("d2_deg.state", 32'(d2_st), 1);
        chk("d2_deg.irq", 32'(d2_irq), 1);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("d2_q1.state", 32'(d2_st), 1);
        tick(); chk("d2_q2.state", 32'(d2_st), 1);
        tick(); chk("d2_q3.state", 32'(d2_st), 0);
        chk("d2_q3.irq", 32'(d2_irq), 1);
        drive(5'h01, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("d2_sat%0d.cnt1", i), 32'(d2_c1), (i > 15) ? 15 : i);
            if (i == 1) begin
                chk("d2_iso.state", 32'(d2_st), 2);
                chk("d2_iso.irq", 32'(d2_irq), 1);
                chk("d2_iso.perm", 32'(d2_perm), 32'b001);
            end
        end
        chk("main_20.cnt1", 32'(c1), 20);
        chk("main_20.state", 32'(st), 2);

        // asynchronous reset mid-run while DEGRADED
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 5'h01, 0, 0); tick();
        chk("pre_rst.state", 32'(st), 1);
        chk("pre_rst.irq", 32'(irq), 1);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        chk("rst_hold.irq", 32'(irq), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d.irq", i), 32'(irq), 0);
            chk($sformatf("post_rst%0d.state", i), 32'(st), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
